// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Purpose : Shared types and constants for the pipeline stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] c_reg_x0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : hazard_detect
// Purpose : Combinational load-use hazard term between the EX load and ID.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_is_s_type,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = (i_ex_rd == i_rs1);
    // Store data is forwarded from WB, so a store's rs2 never needs the bubble.
    assign w_rs2_hit = !i_is_s_type && (i_ex_rd == i_rs2);

    assign o_load_use = i_ex_is_load && (i_ex_rd != c_reg_x0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pipeline_ctrl
// Purpose : Stall/flush sequencer merging memory wait, branch redirect and
//           load-use hazards into per-stage enables, with watchdog and counters.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_is_s_type,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_is_load,
    input  logic             EX_branch_taken,
    input  logic             MEM_dmem_req,
    input  logic             dmem_ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_en,
    output logic             ID_EX_flush,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int c_wait_w = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic [c_wait_w-1:0]   w_next_wait;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_stall_cycles;
    logic [CNT_W-1:0]      r_flush_count;

    logic w_freeze;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    hazard_detect u_hazard_detect (
        .i_rs1        (IF_ID_rs1),
        .i_rs2        (IF_ID_rs2),
        .i_is_s_type  (IF_ID_is_s_type),
        .i_ex_rd      (ID_EX_rd),
        .i_ex_is_load (ID_EX_is_load),
        .o_load_use   (w_load_use)
    );

    assign w_freeze = MEM_dmem_req && !dmem_ready;

    // Only hazards that are actually applied count: a branch squashes the
    // load-use victim, and a frozen branch is counted on its release cycle.
    assign w_stall_inc = w_freeze || (w_load_use && !EX_branch_taken);
    assign w_flush_inc = !w_freeze && EX_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            if (w_freeze && (w_next_wait == c_wait_max)) begin
                r_timeout <= 1'b1;
            end
            if (w_stall_inc) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_inc) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        PC_en        = 1'b0;
        IF_ID_en     = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_en     = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_en    = 1'b0;
        MEM_WB_en    = 1'b0;

        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_next_state = MEM_WAIT;
                    w_next_wait  = c_wait_one;
                end else begin
                    w_next_wait  = '0;
                end
            end
            MEM_WAIT: begin
                if (w_freeze) begin
                    if (r_wait_cnt != c_wait_max) begin
                        w_next_wait = r_wait_cnt + c_wait_one;
                    end
                end else begin
                    w_next_state = RUN;
                    w_next_wait  = '0;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_wait  = '0;
            end
        endcase

        // Freeze holds everything, including any branch or hazard waiting behind it.
        if (!rst && !w_freeze) begin
            if (EX_branch_taken) begin
                PC_en       = 1'b1;
                IF_ID_en    = 1'b1;
                IF_ID_flush = 1'b1;
                ID_EX_en    = 1'b1;
                ID_EX_flush = 1'b1;
                EX_MEM_en   = 1'b1;
                MEM_WB_en   = 1'b1;
            end else if (w_load_use) begin
                ID_EX_en    = 1'b1;
                ID_EX_flush = 1'b1;
                EX_MEM_en   = 1'b1;
                MEM_WB_en   = 1'b1;
            end else begin
                PC_en       = 1'b1;
                IF_ID_en    = 1'b1;
                ID_EX_en    = 1'b1;
                EX_MEM_en   = 1'b1;
                MEM_WB_en   = 1'b1;
            end
        end
    end

    assign mem_timeout  = r_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire
